window_gen_3x3_rgb: RTL and testbench
=====================================

Name: window_gen_3x3_rgb

Overview:
- Neighbourhood generator that sits directly upstream of the 3-channel boost filter.
- Takes a raster-order RGB888 pixel stream and emits, for every pixel, that pixel plus its 8 neighbours, with a one-cycle valid.
- Two internal line buffers hold the previous rows; image borders use edge replication.
- Produces exactly IMG_W*IMG_H windows per frame, in raster order.

Parameters:
- IMG_W, 640: pixels per line; must be at least 3.
- IMG_H, 480: lines per frame; must be at least 2.
- DW, 24: pixel width, packed {R[23:16], G[15:8], B[7:0]}.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- pix_in  in  DW  input pixel, raster order.
- pix_valid  in  1  pix_in is valid.
- pix_ready  out  1  block can accept; a pixel transfers when pix_valid && pix_ready.
- p1..p8  out  DW each  neighbours:
  - p1 top-left, p2 top, p3 top-right;
  - p4 left, p5 right;
  - p6 bottom-left, p7 bottom, p8 bottom-right.
- pixel  out  DW  centre pixel of the window.
- data_in  out  1  window valid; high for one cycle per window.
- frame_done  out  1  one-cycle pulse, coincident with the last window of a frame.

Behaviour:
- Reset: asynchronous, active-high. All of the following clear to 0:
  - outputs p1..p8, pixel, data_in, frame_done;
  - in_col and in_row counters;
  - state goes to FILL.
  - Line-buffer contents are don't-care.
  - Reset mid-frame discards the partial frame; the next accepted pixel is treated as (0,0).
- Counters:
  - in_col counts 0..IMG_W-1; at the end of a line it wraps and in_row increments.
  - in_row counts 0..IMG_H-1 and wraps at end of frame.
- Row storage: two line buffers of IMG_W x DW, ping-ponged per line. Rows r-1 and r are readable while row r+1 is written. A 3-column shift register per row forms the window.
- Replication rules:
  - row -1 uses row 0; row IMG_H uses row IMG_H-1;
  - column -1 uses column 0; column IMG_W uses column IMG_W-1.
- State FILL (input row 0):
  - pix_ready = 1; pixels are stored and no windows are emitted.
  - After (0,IMG_W-1) is accepted, go to RUN.
- State RUN (input rows 1..IMG_H-1):
  - pix_ready = 1.
  - Accepting (r+1,0) emits nothing.
  - Accepting (r+1,c+1) triggers the window centred at (r,c), for c = 0..IMG_W-2.
  - After (r+1,IMG_W-1) is accepted, go to EOL.
- State EOL:
  - One cycle, pix_ready = 0; triggers the window at (r,IMG_W-1).
  - Next state is FLUSH if the last accepted row was IMG_H-1, otherwise RUN.
- State FLUSH:
  - IMG_W consecutive cycles, pix_ready = 0.
  - Trigger windows (IMG_H-1, 0..IMG_W-1).
  - Then go to FILL for the next frame.
- Latency: data_in and the window outputs are registered, asserted the cycle after the trigger.
- Output hold: p*/pixel hold their last value while data_in = 0.
- frame_done asserts in the same cycle as data_in for window (IMG_H-1, IMG_W-1).
- Backpressure: none from downstream. The consumer must take every data_in pulse.
- Input throttling: pix_valid gaps stall progress in FILL and RUN only. EOL and FLUSH proceed regardless of pix_valid.
- Totals per frame:
  - IMG_W*IMG_H windows;
  - 1+IMG_W stall cycles at end of frame;
  - 1 stall cycle at the end of each line for rows 1..IMG_H-2.
- No arithmetic is performed; pixel data passes through bit-exact.

Test Plan (IMG_W=4, IMG_H=3; input pixel (r,c) = {v,v,v} with v = 16*r + c, pix_valid held high):
- Reset in FILL or RUN with pix_valid high -> next cycle data_in = 0, pix_ready = 1. The pixel presented after reset is stored as (0,0); no window appears until the 6th accept.
- Window (0,0) -> data_in first high on the cycle after the 6th accept (pixel (1,1)), with:
  - pixel = 0x000000, p1 = p2 = p4 = 0x000000;
  - p3 = p5 = 0x010101;
  - p6 = p7 = 0x101010, p8 = 0x111111.
- EOL stall -> after accepting (1,3), pix_ready = 0 for exactly one cycle. The window at (0,3) is emitted with p3 = p5 = p8 copying column 3 (0x030303, 0x030303, 0x131313).
- End of frame -> after accepting (2,3), pix_ready is low for 5 cycles, emitting (1,3) then (2,0..3). The last window has:
  - pixel = 0x232323, p1 = 0x121212, p2 = p3 = 0x131313;
  - p4 = p6 = 0x222222, p5 = p7 = p8 = 0x232323;
  - frame_done = 1 in that cycle.
- Over the whole frame: exactly 12 data_in pulses.
- Random pix_valid gaps over 2 back-to-back frames -> window sequence identical to the gap-free run. 24 total windows; frame_done pulses twice; second frame starts correctly with no residue from frame 1.

Source files
------------

// File: rtl/window_gen_3x3_rgb_if.sv
// Pixel-stream input and 3x3 window output bundle for window_gen_3x3_rgb.
// master = pixel source / window consumer, slave = the window generator.
interface window_gen_3x3_rgb_if #(
  parameter int DW = 24
);
  logic [DW-1:0] pix_in;
  logic          pix_valid;
  logic          pix_ready;
  logic [DW-1:0] p1, p2, p3, p4, p5, p6, p7, p8;
  logic [DW-1:0] pixel;
  logic          data_in;
  logic          frame_done;

  modport master (
    output pix_in, pix_valid,
    input  pix_ready, p1, p2, p3, p4, p5, p6, p7, p8, pixel, data_in, frame_done
  );

  modport slave (
    input  pix_in, pix_valid,
    output pix_ready, p1, p2, p3, p4, p5, p6, p7, p8, pixel, data_in, frame_done
  );
endinterface

// File: rtl/window_gen_3x3_rgb.sv
// 3x3 RGB neighbourhood generator: two ping-pong line buffers, a two-column shift
// register and edge replication at every image border.
module window_gen_3x3_rgb #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int DW    = 24
) (
  input  logic               clk,
  input  logic               rst,
  window_gen_3x3_rgb_if.slave win
);
  localparam int COLW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROWW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [COLW-1:0] LAST_COL = COLW'(IMG_W - 1);
  localparam logic [COLW-1:0] COL_ONE  = COLW'(1);
  localparam logic [ROWW-1:0] LAST_ROW = ROWW'(IMG_H - 1);
  localparam logic [ROWW-1:0] ROW_ONE  = ROWW'(1);

  typedef enum logic [1:0] {FILL, RUN, EOL, FLUSH} state_e;

  typedef struct packed {
    logic [DW-1:0] top;
    logic [DW-1:0] mid;
    logic [DW-1:0] bot;
  } col_t;

  state_e state_q, state_d;
  logic [COLW-1:0] in_col_q, in_col_d;
  logic [COLW-1:0] flush_col_q, flush_col_d;
  logic [COLW-1:0] rd_addr;
  logic [ROWW-1:0] in_row_q, in_row_d;
  logic            wr_sel_q, wr_sel_d;
  col_t            ctr_q, ctr_d, right_q, right_d;
  col_t            new_col, left_win, right_win;
  logic [DW-1:0]   line0 [IMG_W];
  logic [DW-1:0]   line1 [IMG_W];
  logic [DW-1:0]   rd_top, rd_mid;
  logic [8:0][DW-1:0] win_q, win_d;
  logic            data_in_q, data_in_d;
  logic            frame_done_q, frame_done_d;
  logic            ready, accept, emit, shift, left_rep, right_rep, flush_mode, last_win;

  // A trigger emits the window centred on right_q; left_rep/right_rep replicate
  // the centre column at the left and right image borders.
  always_comb begin
    state_d     = state_q;
    ready       = 1'b0;
    emit        = 1'b0;
    shift       = 1'b0;
    left_rep    = 1'b0;
    right_rep   = 1'b0;
    flush_mode  = 1'b0;
    last_win    = 1'b0;
    rd_addr     = in_col_q;
    flush_col_d = flush_col_q;
    unique case (state_q)
      FILL: begin
        ready = 1'b1;
        if (win.pix_valid && in_col_q == LAST_COL) state_d = RUN;
      end
      RUN: begin
        ready = 1'b1;
        if (win.pix_valid) begin
          shift    = 1'b1;
          emit     = (in_col_q != '0);
          left_rep = (in_col_q == COL_ONE);
          if (in_col_q == LAST_COL) state_d = EOL;
        end
      end
      EOL: begin
        emit      = 1'b1;
        right_rep = 1'b1;
        if (in_row_q == '0) begin
          // Last row done: preload column 0 of the bottom window row for FLUSH.
          flush_mode  = 1'b1;
          shift       = 1'b1;
          rd_addr     = '0;
          flush_col_d = '0;
          state_d     = FLUSH;
        end else begin
          state_d = RUN;
        end
      end
      FLUSH: begin
        emit        = 1'b1;
        shift       = 1'b1;
        flush_mode  = 1'b1;
        left_rep    = (flush_col_q == '0);
        right_rep   = (flush_col_q == LAST_COL);
        last_win    = right_rep;
        rd_addr     = right_rep ? flush_col_q : flush_col_q + 1'b1;
        flush_col_d = flush_col_q + 1'b1;
        if (right_rep) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  assign accept        = ready && win.pix_valid;
  assign win.pix_ready = ready;

  always_comb begin
    in_col_d = in_col_q;
    in_row_d = in_row_q;
    wr_sel_d = wr_sel_q;
    if (accept) begin
      if (in_col_q == LAST_COL) begin
        in_col_d = '0;
        wr_sel_d = ~wr_sel_q;
        in_row_d = (in_row_q == LAST_ROW) ? '0 : in_row_q + 1'b1;
      end else begin
        in_col_d = in_col_q + 1'b1;
      end
    end
  end

  // The write buffer still holds row r-1 until overwritten, so it is read before the write.
  assign rd_top = wr_sel_q ? line1[rd_addr] : line0[rd_addr];
  assign rd_mid = wr_sel_q ? line0[rd_addr] : line1[rd_addr];

  always_comb begin
    new_col.top = (!flush_mode && in_row_q == ROW_ONE) ? rd_mid : rd_top;
    new_col.mid = rd_mid;
    new_col.bot = flush_mode ? rd_mid : win.pix_in;
    left_win    = left_rep ? right_q : ctr_q;
    right_win   = right_rep ? right_q : new_col;
    ctr_d       = shift ? right_q : ctr_q;
    right_d     = shift ? new_col : right_q;
    win_d       = win_q;
    if (emit) begin
      win_d[0] = left_win.top;
      win_d[1] = right_q.top;
      win_d[2] = right_win.top;
      win_d[3] = left_win.mid;
      win_d[4] = right_q.mid;
      win_d[5] = right_win.mid;
      win_d[6] = left_win.bot;
      win_d[7] = right_q.bot;
      win_d[8] = right_win.bot;
    end
    data_in_d    = emit;
    frame_done_d = last_win;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      if (wr_sel_q) line1[in_col_q] <= win.pix_in;
      else          line0[in_col_q] <= win.pix_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= FILL;
      in_col_q     <= '0;
      in_row_q     <= '0;
      flush_col_q  <= '0;
      wr_sel_q     <= 1'b0;
      ctr_q        <= '0;
      right_q      <= '0;
      win_q        <= '0;
      data_in_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      in_col_q     <= in_col_d;
      in_row_q     <= in_row_d;
      flush_col_q  <= flush_col_d;
      wr_sel_q     <= wr_sel_d;
      ctr_q        <= ctr_d;
      right_q      <= right_d;
      win_q        <= win_d;
      data_in_q    <= data_in_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign win.p1         = win_q[0];
  assign win.p2         = win_q[1];
  assign win.p3         = win_q[2];
  assign win.p4         = win_q[3];
  assign win.pixel      = win_q[4];
  assign win.p5         = win_q[5];
  assign win.p6         = win_q[6];
  assign win.p7         = win_q[7];
  assign win.p8         = win_q[8];
  assign win.data_in    = data_in_q;
  assign win.frame_done = frame_done_q;
endmodule

// File: tb/tb_window_gen_3x3_rgb.sv
// Bench for window_gen_3x3_rgb at 4x3: known-window table, clamp-based reference
// model over whole frames, reset corner cases and randomly gapped input.
module tb_window_gen_3x3_rgb;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int DW = 24;

  logic clk = 1'b0;
  logic rst;

  window_gen_3x3_rgb_if #(.DW(DW)) bus ();

  window_gen_3x3_rgb #(.IMG_W(W), .IMG_H(H), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .win (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] w[9];
    logic          fd;
    int            acc;
  } cap_t;

  typedef struct {
    int            idx;
    logic [DW-1:0] w[9];
    logic          fd;
  } vec_t;

  cap_t          capQ[$];
  int            stallQ[$];
  cap_t          monCap;
  int            accCnt = 0;
  int            lowRun = 0;
  int            fdCnt  = 0;
  int            nChecks = 0;
  int            nFail   = 0;
  logic [DW-1:0] img [2][H][W];

  // Window order in w[]: p1 p2 p3 p4 pixel p5 p6 p7 p8 (raster order of the 3x3).
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.data_in) begin
        monCap.w[0] = bus.p1;    monCap.w[1] = bus.p2;    monCap.w[2] = bus.p3;
        monCap.w[3] = bus.p4;    monCap.w[4] = bus.pixel; monCap.w[5] = bus.p5;
        monCap.w[6] = bus.p6;    monCap.w[7] = bus.p7;    monCap.w[8] = bus.p8;
        monCap.fd   = bus.frame_done;
        monCap.acc  = accCnt;
        capQ.push_back(monCap);
      end
      if (bus.frame_done) fdCnt++;
      if (bus.pix_valid && bus.pix_ready) accCnt++;
      if (!bus.pix_ready) lowRun++;
      else if (lowRun > 0) begin
        stallQ.push_back(lowRun);
        lowRun = 0;
      end
    end
  end

  function automatic string fieldName(input int k);
    case (k)
      0: return "p1";
      1: return "p2";
      2: return "p3";
      3: return "p4";
      4: return "pixel";
      5: return "p5";
      6: return "p6";
      7: return "p7";
      default: return "p8";
    endcase
  endfunction

  // Reference: neighbour k of window (r,c), borders clamped into the image.
  function automatic logic [DW-1:0] modelPix(input int f, input int r, input int c, input int k);
    int rr, cc;
    rr = r + k / 3 - 1;
    cc = c + k % 3 - 1;
    if (rr < 0) rr = 0;
    if (rr > H - 1) rr = H - 1;
    if (cc < 0) cc = 0;
    if (cc > W - 1) cc = W - 1;
    return img[f][rr][cc];
  endfunction

  function automatic vec_t mkVec(input int idx,
                                 input logic [DW-1:0] a0, input logic [DW-1:0] a1, input logic [DW-1:0] a2,
                                 input logic [DW-1:0] a3, input logic [DW-1:0] a4, input logic [DW-1:0] a5,
                                 input logic [DW-1:0] a6, input logic [DW-1:0] a7, input logic [DW-1:0] a8,
                                 input logic fd);
    vec_t v;
    v.idx = idx;
    v.w[0] = a0; v.w[1] = a1; v.w[2] = a2;
    v.w[3] = a3; v.w[4] = a4; v.w[5] = a5;
    v.w[6] = a6; v.w[7] = a7; v.w[8] = a8;
    v.fd = fd;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sendPixel(input logic [DW-1:0] v, input int gapPct);
    bit done;
    int guard;
    while (gapPct > 0 && $urandom_range(0, 99) < gapPct) begin
      bus.pix_valid = 1'b0;
      @(posedge clk); #1;
    end
    bus.pix_in    = v;
    bus.pix_valid = 1'b1;
    done  = 1'b0;
    guard = 0;
    while (!done && guard < 64) begin
      @(negedge clk);
      done = bus.pix_ready;
      guard++;
      @(posedge clk); #1;
    end
    if (!done) begin
      nChecks++;
      nFail++;
      $display("[TB] FAIL accept timeout: pix_ready stayed 0 for %0d cycles, required 1", guard);
    end
    bus.pix_valid = 1'b0;
  endtask

  task automatic applyStimulus(input int f, input int gapPct);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        sendPixel(img[f][r][c], gapPct);
  endtask

  task automatic checkFrame(input string tag, input int f, input int base);
    for (int i = 0; i < W * H; i++) begin
      if (base + i < capQ.size()) begin
        for (int k = 0; k < 9; k++)
          checkOutput($sformatf("%s win(%0d,%0d) %s", tag, i / W, i % W, fieldName(k)),
                      32'(capQ[base + i].w[k]), 32'(modelPix(f, i / W, i % W, k)));
        checkOutput($sformatf("%s win(%0d,%0d) frame_done", tag, i / W, i % W),
                    32'(capQ[base + i].fd), (i == W * H - 1) ? 32'd1 : 32'd0);
      end
    end
  endtask

  task automatic checkStalls(input string tag, input int base, input int frames);
    checkOutput($sformatf("%s stall run count", tag), 32'(stallQ.size() - base), 32'(2 * frames));
    for (int i = 0; i < 2 * frames; i++)
      if (base + i < stallQ.size())
        checkOutput($sformatf("%s stall run %0d length", tag, i), 32'(stallQ[base + i]),
                    (i % 2 == 0) ? 32'd1 : 32'(1 + W));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t vecs[4];
    int capBase, stallBase, accBase, fdBase;

    rst           = 1'b1;
    bus.pix_valid = 1'b0;
    bus.pix_in    = '0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        img[0][r][c] = {3{8'(16 * r + c)}};
        img[1][r][c] = DW'($urandom);
      end

    vecs[0] = mkVec(0,  24'h000000, 24'h000000, 24'h010101, 24'h000000, 24'h000000, 24'h010101,
                        24'h101010, 24'h101010, 24'h111111, 1'b0);
    vecs[1] = mkVec(3,  24'h020202, 24'h030303, 24'h030303, 24'h020202, 24'h030303, 24'h030303,
                        24'h121212, 24'h131313, 24'h131313, 1'b0);
    vecs[2] = mkVec(4,  24'h000000, 24'h000000, 24'h010101, 24'h101010, 24'h101010, 24'h111111,
                        24'h202020, 24'h202020, 24'h212121, 1'b0);
    vecs[3] = mkVec(11, 24'h121212, 24'h131313, 24'h131313, 24'h222222, 24'h232323, 24'h232323,
                        24'h222222, 24'h232323, 24'h232323, 1'b1);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset data_in", 32'(bus.data_in), 32'd0);
    checkOutput("reset frame_done", 32'(bus.frame_done), 32'd0);
    checkOutput("reset pix_ready", 32'(bus.pix_ready), 32'd1);
    checkOutput("reset pixel", 32'(bus.pixel), 32'd0);
    checkOutput("reset p8", 32'(bus.p8), 32'd0);
    @(posedge clk); #1;

    // Abandon a frame part-way through row 1, just as its second window is emitted.
    for (int i = 0; i < 7; i++) sendPixel(DW'($urandom), 0);
    bus.pix_in    = 24'hABCDEF;
    bus.pix_valid = 1'b1;
    rst           = 1'b1;
    @(negedge clk);
    checkOutput("mid-frame reset data_in", 32'(bus.data_in), 32'd0);
    checkOutput("mid-frame reset pix_ready", 32'(bus.pix_ready), 32'd1);
    checkOutput("mid-frame reset pixel", 32'(bus.pixel), 32'd0);
    checkOutput("mid-frame reset p3", 32'(bus.p3), 32'd0);
    @(posedge clk); #1;
    rst           = 1'b0;
    bus.pix_valid = 1'b0;
    @(posedge clk); #1;

    capBase = capQ.size(); stallBase = stallQ.size(); accBase = accCnt; fdBase = fdCnt;
    applyStimulus(0, 0);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("frameA window count", 32'(capQ.size() - capBase), 32'(W * H));
    if (capQ.size() > capBase)
      checkOutput("frameA first window accept index", 32'(capQ[capBase].acc - accBase), 32'd6);
    for (int i = 0; i < 4; i++) begin
      if (capBase + vecs[i].idx < capQ.size()) begin
        for (int k = 0; k < 9; k++)
          checkOutput($sformatf("table win %0d %s", vecs[i].idx, fieldName(k)),
                      32'(capQ[capBase + vecs[i].idx].w[k]), 32'(vecs[i].w[k]));
        checkOutput($sformatf("table win %0d frame_done", vecs[i].idx),
                    32'(capQ[capBase + vecs[i].idx].fd), 32'(vecs[i].fd));
      end
    end
    checkFrame("frameA", 0, capBase);
    checkStalls("frameA", stallBase, 1);
    checkOutput("frameA frame_done pulses", 32'(fdCnt - fdBase), 32'd1);

    capBase = capQ.size(); stallBase = stallQ.size(); accBase = accCnt; fdBase = fdCnt;
    applyStimulus(0, 30);
    applyStimulus(1, 30);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("gapped window count", 32'(capQ.size() - capBase), 32'(2 * W * H));
    if (capQ.size() > capBase)
      checkOutput("gapped frame0 first window accept index", 32'(capQ[capBase].acc - accBase), 32'd6);
    if (capQ.size() > capBase + W * H)
      checkOutput("gapped frame1 first window accept index",
                  32'(capQ[capBase + W * H].acc - accBase), 32'(W * H + 6));
    checkFrame("gapped0", 0, capBase);
    checkFrame("gapped1", 1, capBase + W * H);
    checkStalls("gapped", stallBase, 2);
    checkOutput("gapped frame_done pulses", 32'(fdCnt - fdBase), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule
